spart: RTL and testbench
========================

# spart

Special-purpose asynchronous receiver/transmitter: the bus-side responder for the processor's 2-bit-address, 8-bit-bidirectional I/O bus (iocs/iorw/ioaddr/databus). It holds a programmable 16-bit baud divisor, serializes bytes written by the bus initiator onto txd, deserializes rxd into a receive buffer, and reports tbr/rda status. It sits between the bus initiator and the board's UART pins.

## Interface
- DIV_RESET, 16'h1458, divisor loaded at reset (clocks per bit)
- DIV_MIN, 2, smallest effective divisor; programmed values below it are clamped
- clk  input  1  system clock
- rst  input  1  asynchronous, active-low reset
- iocs  input  1  chip select; bus access only when 1
- iorw  input  1  1 = read (spart drives databus), 0 = write
- ioaddr  input  2  register select
- databus  inout  8  bidirectional data; spart drives only when iocs && iorw
- rda  output  1  receive data available
- tbr  output  1  transmit buffer ready
- txd  output  1  serial out, idle high
- rxd  input  1  serial in, asynchronous to clk

## Operation
- Address map:
  - 00: write = transmit byte; read = receive buffer.
  - 01: read = status {5'b0, ferr, tbr, rda}; writes ignored.
  - 10: DB low byte, write-only.
  - 11: DB high byte, write-only.
  - Reads of 10/11 return 8'h00.
- Reset values:
  - divisor = DIV_RESET, tbr = 1, rda = 0, txd = 1, ferr = 0, receive buffer = 8'h00.
  - Both FSMs in idle; databus high-Z.
- Frame: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1); each bit lasts exactly D = max(divisor, DIV_MIN) clocks.
- TX FSM: TX_IDLE → TX_SHIFT (10 bit-times, 4-bit bit counter, 16-bit down-counter) → TX_IDLE.
  - A write to 00 with tbr = 1 loads the shift register, sets tbr = 0 and starts the frame.
  - A write to 00 with tbr = 0 is ignored; the frame in flight is unchanged.
- RX FSM: RX_IDLE → RX_START → RX_DATA → RX_STOP → RX_IDLE.
  - rxd passes through a 2-flop synchronizer.
  - A falling edge in RX_IDLE starts the frame; the start bit is rechecked after D/2 clocks (integer floor).
  - If the line is high at that point, return to RX_IDLE (glitch rejected).
  - Otherwise sample every D clocks: 8 data bits, then the stop bit.
  - At the end of RX_STOP, the byte moves to the receive buffer and rda is set.
- Read of 00: clears rda on that clock edge.
- Overrun: a new byte overwrites the buffer; rda stays 1.
- Simultaneous events:
  - Buffer-load in the same cycle as a read of 00: the read returns the old byte, and rda ends up 1 (set wins).
  - Writes to 10/11 take effect immediately; a frame in progress finishes its current bit with the old count and uses the new D from the next bit boundary.
- Reset mid-frame aborts both FSMs immediately: txd = 1, tbr = 1, partial RX byte discarded.

## Timing
- Read data is combinational: databus is valid in the same cycle iocs && iorw && ioaddr are presented.
- Register writes are captured at the clock edge where iocs && !iorw.
- TX latency:
  - txd falls on the edge after the write.
  - tbr = 0 from that edge until the edge ending the stop bit, 10·D clocks later; tbr = 1 on that edge.
- RX latency: rda rises 2 (synchronizer) + D/2 + 9·D clocks after the rxd falling edge, ±1 clock.
- Status bits reflect register state as of the current cycle; there is no extra pipeline stage.

## Configuration
- SPART_FRAMING_CHECK_EN defined:
  - A stop bit sampled as 0 discards the byte: buffer unchanged, rda unchanged.
  - ferr sets; it clears on a read of 01.
- Not defined: the stop bit is sampled but ignored, the byte is always delivered, and the ferr status bit reads 0.

## Structure
- spart_pkg holds:
  - Address constants ADDR_BUF/ADDR_STATUS/ADDR_DBL/ADDR_DBH.
  - DIV_MIN default and DIV_RESET default.
  - The tx_state_t and rx_state_t enums.
- One sub-module, spart_rx: synchronizer, RX FSM, shift register, framing check. It outputs byte + byte_valid (+ frame_err) to the top.
- The top-level spart contains the bus decode, divisor registers, TX FSM, status and tristate.

## Test plan
- Reset then idle: txd = 1, tbr = 1, rda = 0, databus high-Z with iocs = 0; status read returns 8'h02.
- Write DB = 16'h0010 (10 then 11), write 8'hA5 to 00:
  - txd shows 0,1,0,1,0,0,1,0,1,1, each exactly 16 clocks.
  - tbr is low for 160 clocks.
  - A second write mid-frame is ignored.
- Drive rxd with 8'h3C at D = 16: rda rises; read of 00 returns 8'h3C and rda clears the next cycle.
- Overrun and collision:
  - Receive 8'h11 then 8'h22 without reading: read returns 8'h22.
  - Buffer-load coincident with a read: old byte returned, rda = 1.
- Glitch and framing:
  - An 4-clock low pulse on rxd produces no rda.
  - Frame 8'h55 with stop bit 0, with the macro defined: rda stays 0 and status = 8'h06, then 8'h02 after the read.
  - Without the macro: rda = 1 and data = 8'h55.
- Reset mid-frame:
  - Assert rst during TX bit 4: txd = 1 and tbr = 1 immediately.
  - After release, 8'hFF transmits cleanly at DIV_RESET.

Source files
------------

// File: rtl/spart_pkg.sv
// Shared definitions for the spart serial port: register addresses, divisor defaults,
// FSM state types and the divisor clamp helper.
package spart_pkg;

  localparam logic [1:0] ADDR_BUF    = 2'b00;
  localparam logic [1:0] ADDR_STATUS = 2'b01;
  localparam logic [1:0] ADDR_DBL    = 2'b10;
  localparam logic [1:0] ADDR_DBH    = 2'b11;

  localparam logic [15:0] DIV_MIN_DEFAULT   = 16'd2;
  localparam logic [15:0] DIV_RESET_DEFAULT = 16'h1458;

  typedef enum logic {
    TX_IDLE,
    TX_SHIFT
  } tx_state_t;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_t;

  function automatic logic [15:0] clamp_div(input logic [15:0] div, input logic [15:0] div_min);
    return (div < div_min) ? div_min : div;
  endfunction

endpackage

// File: rtl/spart_if.sv
// Processor-side I/O bus control and status signals of spart (databus stays a plain inout port).
interface spart_if;
  logic       iocs;
  logic       iorw;
  logic [1:0] ioaddr;
  logic       rda;
  logic       tbr;

  modport master (output iocs, iorw, ioaddr, input rda, tbr);
  modport slave  (input iocs, iorw, ioaddr, output rda, tbr);
endinterface

// File: rtl/spart_rx.sv
// spart receiver: rxd synchronizer, start-bit recheck, 8N1 deserializer.
// SPART_FRAMING_CHECK_EN: a low stop bit drops the byte and raises frame_err.
module spart_rx
  import spart_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        rxd,
  input  logic [15:0] div,
  output logic [7:0]  rx_byte,
  output logic        byte_valid,
  output logic        frame_err
);

  rx_state_t   state;
  logic        rxd_s1, rxd_s2, rxd_prev;
  logic [15:0] cnt;
  logic [2:0]  bit_cnt;
  logic [7:0]  shreg;
  logic        tick;

  assign tick    = (cnt == 16'd0);
  assign rx_byte = shreg;

  // Delivery is flagged combinationally on the stop-sample edge so the buffer loads on it.
`ifdef SPART_FRAMING_CHECK_EN
  assign byte_valid = (state == RX_STOP) && tick && rxd_s2;
  assign frame_err  = (state == RX_STOP) && tick && !rxd_s2;
`else
  assign byte_valid = (state == RX_STOP) && tick;
  assign frame_err  = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rxd_s1   <= 1'b1;
      rxd_s2   <= 1'b1;
      rxd_prev <= 1'b1;
      state    <= RX_IDLE;
      cnt      <= 16'd0;
      bit_cnt  <= 3'd0;
      shreg    <= 8'h00;
    end else begin
      rxd_s1   <= rxd;
      rxd_s2   <= rxd_s1;
      rxd_prev <= rxd_s2;
      case (state)
        RX_IDLE: begin
          if (rxd_prev && !rxd_s2) begin
            state <= RX_START;
            cnt   <= (div >> 1) - 16'd1;
          end
        end
        RX_START: begin
          if (tick) begin
            if (rxd_s2) begin
              state <= RX_IDLE;
            end else begin
              state   <= RX_DATA;
              cnt     <= div - 16'd1;
              bit_cnt <= 3'd0;
            end
          end else begin
            cnt <= cnt - 16'd1;
          end
        end
        RX_DATA: begin
          if (tick) begin
            shreg   <= {rxd_s2, shreg[7:1]};
            cnt     <= div - 16'd1;
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) state <= RX_STOP;
          end else begin
            cnt <= cnt - 16'd1;
          end
        end
        RX_STOP: begin
          if (tick) state <= RX_IDLE;
          else      cnt   <= cnt - 16'd1;
        end
        default: state <= RX_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/spart.sv
// spart top: bus decode, baud divisor, TX serializer, status/receive buffer and databus tristate.
// SPART_FRAMING_CHECK_EN (handled in spart_rx) enables the ferr status bit.
module spart
  import spart_pkg::*;
#(
  parameter logic [15:0] DIV_RESET = DIV_RESET_DEFAULT,
  parameter logic [15:0] DIV_MIN   = DIV_MIN_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  spart_if.slave     bus,
  inout  wire  [7:0] databus,
  output logic       txd,
  input  logic       rxd
);

  tx_state_t   tx_state;
  logic [7:0]  div_lo, div_hi;
  logic [15:0] div_eff;
  logic [15:0] tx_cnt;
  logic [3:0]  tx_bit;
  logic [8:0]  tx_shreg;
  logic [7:0]  rx_buf, rx_byte, rdata, wdata;
  logic        rda, tbr, ferr;
  logic        byte_valid, frame_err;
  logic        wr_en, rd_en, tx_load, rd_buf, rd_status;

  assign div_eff   = clamp_div({div_hi, div_lo}, DIV_MIN);
  assign wr_en     = bus.iocs && !bus.iorw;
  assign rd_en     = bus.iocs && bus.iorw;
  assign wdata     = databus;
  assign tx_load   = wr_en && (bus.ioaddr == ADDR_BUF) && tbr;
  assign rd_buf    = rd_en && (bus.ioaddr == ADDR_BUF);
  assign rd_status = rd_en && (bus.ioaddr == ADDR_STATUS);

  always_comb begin
    rdata = 8'h00;
    case (bus.ioaddr)
      ADDR_BUF:    rdata = rx_buf;
      ADDR_STATUS: rdata = {5'b00000, ferr, tbr, rda};
      default:     rdata = 8'h00;
    endcase
  end

  assign databus = rd_en ? rdata : 8'hzz;
  assign bus.rda = rda;
  assign bus.tbr = tbr;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_lo <= DIV_RESET[7:0];
      div_hi <= DIV_RESET[15:8];
    end else if (wr_en) begin
      if (bus.ioaddr == ADDR_DBL) div_lo <= wdata;
      if (bus.ioaddr == ADDR_DBH) div_hi <= wdata;
    end
  end

  // Each bit reloads from the live divisor, so a new D applies from the next bit boundary.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_state <= TX_IDLE;
      txd      <= 1'b1;
      tbr      <= 1'b1;
      tx_cnt   <= 16'd0;
      tx_bit   <= 4'd0;
      tx_shreg <= 9'h1FF;
    end else begin
      case (tx_state)
        TX_IDLE: begin
          if (tx_load) begin
            tx_state <= TX_SHIFT;
            txd      <= 1'b0;
            tbr      <= 1'b0;
            tx_cnt   <= div_eff - 16'd1;
            tx_bit   <= 4'd0;
            tx_shreg <= {1'b1, wdata};
          end
        end
        TX_SHIFT: begin
          if (tx_cnt != 16'd0) begin
            tx_cnt <= tx_cnt - 16'd1;
          end else if (tx_bit == 4'd9) begin
            tx_state <= TX_IDLE;
            txd      <= 1'b1;
            tbr      <= 1'b1;
          end else begin
            txd      <= tx_shreg[0];
            tx_shreg <= {1'b1, tx_shreg[8:1]};
            tx_bit   <= tx_bit + 4'd1;
            tx_cnt   <= div_eff - 16'd1;
          end
        end
        default: tx_state <= TX_IDLE;
      endcase
    end
  end

  // A buffer load beats a simultaneous read clear; the read still sees the old byte.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_buf <= 8'h00;
      rda    <= 1'b0;
      ferr   <= 1'b0;
    end else begin
      if (byte_valid) rx_buf <= rx_byte;
      if (byte_valid)  rda <= 1'b1;
      else if (rd_buf) rda <= 1'b0;
      if (frame_err)      ferr <= 1'b1;
      else if (rd_status) ferr <= 1'b0;
    end
  end

  spart_rx u_rx (
    .clk        (clk),
    .rst        (rst),
    .rxd        (rxd),
    .div        (div_eff),
    .rx_byte    (rx_byte),
    .byte_valid (byte_valid),
    .frame_err  (frame_err)
  );

endmodule

// File: tb/tb_spart.sv
// Directed self-checking bench for spart: bus access, TX/RX framing, overrun, collision,
// glitch rejection, divisor clamp and reset mid-frame.
module tb_spart;
  import spart_pkg::*;

  localparam int DT = 16;
  localparam int DR = 5208;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       rxd = 1'b1;
  logic       tb_oe = 1'b0;
  logic [7:0] tb_d = 8'h00;
  wire  [7:0] databus;
  logic       txd;
  int         n_checks = 0;
  int         n_fail = 0;

  spart_if bus_if();

  spart dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus_if),
    .databus (databus),
    .txd     (txd),
    .rxd     (rxd)
  );

  assign databus = tb_oe ? tb_d : 8'hzz;

  always #5 clk = ~clk;

  task automatic bus_write(input logic [1:0] addr, input logic [7:0] data);
    @(negedge clk);
    bus_if.iocs = 1'b1; bus_if.iorw = 1'b0; bus_if.ioaddr = addr;
    tb_d = data; tb_oe = 1'b1;
    @(negedge clk);
    bus_if.iocs = 1'b0; tb_oe = 1'b0;
  endtask

  task automatic bus_read(input logic [1:0] addr, output logic [7:0] data);
    @(negedge clk);
    bus_if.iocs = 1'b1; bus_if.iorw = 1'b1; bus_if.ioaddr = addr;
    #1 data = databus;
    @(negedge clk);
    bus_if.iocs = 1'b0;
  endtask

  // Drives one frame on rxd; optionally performs a buffer read at iteration rd_at.
  task automatic send_frame(input logic [7:0] data, input logic stop, input int rd_at,
                            output int rda_at, output logic [7:0] rd_val);
    logic [9:0] bits;
    bits   = {stop, data, 1'b0};
    rda_at = -1;
    rd_val = 8'h00;
    for (int j = 0; j < 10 * DT; j++) begin
      rxd = bits[j / DT];
      if (j == rd_at) begin
        bus_if.iocs = 1'b1; bus_if.iorw = 1'b1; bus_if.ioaddr = ADDR_BUF;
        #1 rd_val = databus;
      end else if (j == rd_at + 1) begin
        bus_if.iocs = 1'b0;
      end
      @(negedge clk);
      if (rda_at < 0 && bus_if.rda === 1'b1) rda_at = j + 1;
    end
    rxd = 1'b1;
  endtask

  task automatic test_reset;
    logic [7:0] d;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (txd !== 1'b1 || bus_if.tbr !== 1'b1 || bus_if.rda !== 1'b0) begin
      n_fail++; $display("FAIL reset_hold: txd=%b tbr=%b rda=%b expected 1 1 0", txd, bus_if.tbr, bus_if.rda);
    end
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++;
    if (txd !== 1'b1 || bus_if.tbr !== 1'b1 || bus_if.rda !== 1'b0) begin
      n_fail++; $display("FAIL reset_idle: txd=%b tbr=%b rda=%b expected 1 1 0", txd, bus_if.tbr, bus_if.rda);
    end
    tb_d = 8'h5A; tb_oe = 1'b1;
    #1;
    n_checks++;
    if (databus !== 8'h5A) begin
      n_fail++; $display("FAIL bus_release: databus=%h expected 5a", databus);
    end
    tb_oe = 1'b0;
    bus_read(ADDR_STATUS, d);
    n_checks++;
    if (d !== 8'h02) begin n_fail++; $display("FAIL reset_status: got %h expected 02", d); end
    bus_read(ADDR_BUF, d);
    n_checks++;
    if (d !== 8'h00) begin n_fail++; $display("FAIL reset_buf: got %h expected 00", d); end
    bus_read(ADDR_DBH, d);
    n_checks++;
    if (d !== 8'h00) begin n_fail++; $display("FAIL dbh_read: got %h expected 00", d); end
  endtask

  task automatic test_tx;
    logic [9:0] fr;
    int tbr_low;
    tbr_low = 0;
    fr = {1'b1, 8'hA5, 1'b0};
    bus_write(ADDR_DBL, 8'h10);
    bus_write(ADDR_DBH, 8'h00);
    bus_write(ADDR_BUF, 8'hA5);
    for (int i = 0; i < 10 * DT; i++) begin
      n_checks++;
      if (txd !== fr[i / DT]) begin
        n_fail++; $display("FAIL tx_bit: cycle %0d txd=%b expected %b", i, txd, fr[i / DT]);
      end
      if (bus_if.tbr === 1'b0) tbr_low++;
      if (i == 40) begin
        bus_if.iocs = 1'b1; bus_if.iorw = 1'b0; bus_if.ioaddr = ADDR_BUF;
        tb_d = 8'h00; tb_oe = 1'b1;
      end else if (i == 41) begin
        bus_if.iocs = 1'b0; tb_oe = 1'b0;
      end
      @(negedge clk);
    end
    n_checks++;
    if (tbr_low != 10 * DT) begin n_fail++; $display("FAIL tbr_low: got %0d expected %0d", tbr_low, 10 * DT); end
    n_checks++;
    if (bus_if.tbr !== 1'b1 || txd !== 1'b1) begin
      n_fail++; $display("FAIL tx_done: tbr=%b txd=%b expected 1 1", bus_if.tbr, txd);
    end
  endtask

  task automatic test_rx;
    int at;
    logic [7:0] d, rv;
    send_frame(8'h3C, 1'b1, -1, at, rv);
    n_checks++;
    if (at < 154 || at > 156) begin n_fail++; $display("FAIL rx_latency: got %0d expected 155", at); end
    n_checks++;
    if (bus_if.rda !== 1'b1) begin n_fail++; $display("FAIL rx_rda: got %b expected 1", bus_if.rda); end
    bus_read(ADDR_BUF, d);
    n_checks++;
    if (d !== 8'h3C) begin n_fail++; $display("FAIL rx_data: got %h expected 3c", d); end
    n_checks++;
    if (bus_if.rda !== 1'b0) begin n_fail++; $display("FAIL rda_clear: got %b expected 0", bus_if.rda); end
  endtask

  task automatic test_overrun;
    int at;
    logic [7:0] d, rv;
    send_frame(8'h11, 1'b1, -1, at, rv);
    send_frame(8'h22, 1'b1, -1, at, rv);
    n_checks++;
    if (bus_if.rda !== 1'b1) begin n_fail++; $display("FAIL overrun_rda: got %b expected 1", bus_if.rda); end
    bus_read(ADDR_BUF, d);
    n_checks++;
    if (d !== 8'h22) begin n_fail++; $display("FAIL overrun_data: got %h expected 22", d); end
  endtask

  task automatic test_collision;
    int at;
    logic [7:0] d, rv;
    send_frame(8'h77, 1'b1, 154, at, rv);
    n_checks++;
    if (rv !== 8'h22) begin n_fail++; $display("FAIL collide_old: got %h expected 22", rv); end
    n_checks++;
    if (bus_if.rda !== 1'b1) begin n_fail++; $display("FAIL collide_rda: got %b expected 1", bus_if.rda); end
    bus_read(ADDR_BUF, d);
    n_checks++;
    if (d !== 8'h77) begin n_fail++; $display("FAIL collide_new: got %h expected 77", d); end
  endtask

  task automatic test_glitch;
    logic seen;
    logic [7:0] d;
    seen = 1'b0;
    rxd = 1'b0;
    repeat (4) @(negedge clk);
    rxd = 1'b1;
    repeat (200) begin
      @(negedge clk);
      if (bus_if.rda === 1'b1) seen = 1'b1;
    end
    n_checks++;
    if (seen !== 1'b0) begin n_fail++; $display("FAIL glitch_rda: got %b expected 0", seen); end
    bus_read(ADDR_STATUS, d);
    n_checks++;
    if (d !== 8'h02) begin n_fail++; $display("FAIL glitch_status: got %h expected 02", d); end
  endtask

  task automatic test_framing;
    int at;
    logic [7:0] d, rv;
    send_frame(8'h55, 1'b0, -1, at, rv);
    rxd = 1'b1;
    repeat (4) @(negedge clk);
`ifdef SPART_FRAMING_CHECK_EN
    n_checks++;
    if (bus_if.rda !== 1'b0) begin n_fail++; $display("FAIL ferr_rda: got %b expected 0", bus_if.rda); end
    bus_read(ADDR_STATUS, d);
    n_checks++;
    if (d !== 8'h06) begin n_fail++; $display("FAIL ferr_status: got %h expected 06", d); end
    bus_read(ADDR_STATUS, d);
    n_checks++;
    if (d !== 8'h02) begin n_fail++; $display("FAIL ferr_clear: got %h expected 02", d); end
    bus_read(ADDR_BUF, d);
    n_checks++;
    if (d !== 8'h77) begin n_fail++; $display("FAIL ferr_buf: got %h expected 77", d); end
`else
    n_checks++;
    if (bus_if.rda !== 1'b1) begin n_fail++; $display("FAIL nochk_rda: got %b expected 1", bus_if.rda); end
    bus_read(ADDR_BUF, d);
    n_checks++;
    if (d !== 8'h55) begin n_fail++; $display("FAIL nochk_data: got %h expected 55", d); end
    bus_read(ADDR_STATUS, d);
    n_checks++;
    if (d !== 8'h02) begin n_fail++; $display("FAIL nochk_status: got %h expected 02", d); end
`endif
  endtask

  task automatic test_div_min;
    logic [9:0] fr;
    int bad, tbr_low;
    bad = 0; tbr_low = 0;
    fr = {1'b1, 8'h01, 1'b0};
    bus_write(ADDR_DBL, 8'h01);
    bus_write(ADDR_BUF, 8'h01);
    for (int i = 0; i < 20; i++) begin
      if (txd !== fr[i / 2]) bad++;
      if (bus_if.tbr === 1'b0) tbr_low++;
      @(negedge clk);
    end
    n_checks++;
    if (bad != 0) begin n_fail++; $display("FAIL divmin_wave: %0d wrong cycles expected 0", bad); end
    n_checks++;
    if (tbr_low != 20 || bus_if.tbr !== 1'b1) begin
      n_fail++; $display("FAIL divmin_tbr: low %0d tbr=%b expected 20 1", tbr_low, bus_if.tbr);
    end
    bus_write(ADDR_DBL, 8'h10);
  endtask

  task automatic test_reset_midframe;
    int bad, tbr_low;
    logic rda_seen;
    bad = 0; tbr_low = 0; rda_seen = 1'b0;
    bus_write(ADDR_BUF, 8'h00);
    rxd = 1'b0;
    repeat (70) @(negedge clk);
    n_checks++;
    if (txd !== 1'b0 || bus_if.tbr !== 1'b0) begin
      n_fail++; $display("FAIL pre_reset: txd=%b tbr=%b expected 0 0", txd, bus_if.tbr);
    end
    #2 rst = 1'b0;
    #1;
    n_checks++;
    if (txd !== 1'b1 || bus_if.tbr !== 1'b1) begin
      n_fail++; $display("FAIL reset_async: txd=%b tbr=%b expected 1 1", txd, bus_if.tbr);
    end
    rxd = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    bus_write(ADDR_BUF, 8'hFF);
    for (int i = 0; i < 10 * DR; i++) begin
      if (txd !== ((i < DR) ? 1'b0 : 1'b1)) bad++;
      if (bus_if.tbr === 1'b0) tbr_low++;
      if (bus_if.rda === 1'b1) rda_seen = 1'b1;
      @(negedge clk);
    end
    n_checks++;
    if (bad != 0) begin n_fail++; $display("FAIL ff_wave: %0d wrong cycles expected 0", bad); end
    n_checks++;
    if (tbr_low != 10 * DR || bus_if.tbr !== 1'b1) begin
      n_fail++; $display("FAIL ff_tbr: low %0d tbr=%b expected %0d 1", tbr_low, bus_if.tbr, 10 * DR);
    end
    n_checks++;
    if (rda_seen !== 1'b0) begin n_fail++; $display("FAIL rx_abort: rda seen %b expected 0", rda_seen); end
  endtask

  initial begin
    bus_if.iocs = 1'b0;
    bus_if.iorw = 1'b0;
    bus_if.ioaddr = 2'b00;
    test_reset();
    test_tx();
    test_rx();
    test_overrun();
    test_collision();
    test_glitch();
    test_framing();
    test_div_min();
    test_reset_midframe();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
